// File: rtl/rv32i_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and
// the width of the little-endian payload length field.
package rv32i_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam int LEN_W = 16;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed image into the instruction memory
// write port, holding the core in stall until the image is verified.
module imem_loader
    import rv32i_pkg::*;
#(
    parameter int ElemWidth = 8,
    parameter int Depth     = 120,
    parameter int AW        = 7,
    parameter int BASE      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    input  logic [ElemWidth-1:0] s_data,
    output logic                 s_ready,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [ElemWidth-1:0] mem_wdata,
    output logic                 core_stall,
    output logic                 core_flush,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    loader_state_t        state, stateNext;
    logic [LEN_W-1:0]     len;
    logic [LEN_W-1:0]     count;
    logic [ElemWidth-1:0] csum;
    logic [LEN_W-1:0]     lenFull;

    // Length bytes are always 8 bits wide regardless of ElemWidth.
    assign lenFull = {s_data[7:0], len[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        s_ready    = 1'b0;
        core_flush = 1'b0;
        core_stall = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) stateNext = LEN_LO;
            end
            LEN_LO: begin
                s_ready = 1'b1;
                if (s_valid) stateNext = LEN_HI;
            end
            LEN_HI: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (lenFull > LEN_W'(Depth))  stateNext = ERR;
                    else if (lenFull == '0)       stateNext = CSUM;
                    else                          stateNext = DATA;
                end
            end
            DATA: begin
                s_ready = 1'b1;
                if (s_valid && (count == len - LEN_W'(1))) stateNext = CSUM;
            end
            CSUM: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_data == csum) begin
                        stateNext  = DONE;
                        core_flush = 1'b1;
                    end else begin
                        stateNext = ERR;
                    end
                end
            end
            DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                core_stall = 1'b0;
                if (start) stateNext = LEN_LO;
            end
            ERR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (start) stateNext = LEN_LO;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Write port is registered: a payload byte accepted in cycle n is
    // written in cycle n+1, so back-to-back bytes give back-to-back writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len       <= '0;
            count     <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= AW'(BASE);
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (s_valid) begin
                case (state)
                    LEN_LO: len[7:0] <= s_data[7:0];
                    LEN_HI: begin
                        len   <= lenFull;
                        count <= '0;
                        csum  <= '0;
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= AW'(BASE) + count[AW-1:0];
                        mem_wdata <= s_data;
                        csum      <= csum + s_data;
                        count     <= count + LEN_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table for whole frames,
// plus hand sequences for stream stalls and reset in the middle of a load.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_stall;
    logic       core_flush;
    logic       busy;
    logic       done;
    logic       err;

    int nChecks = 0;
    int nFail   = 0;

    logic [6:0] wrAddr[$];
    logic [7:0] wrData[$];
    int         flushCount = 0;

    imem_loader #(
        .ElemWidth(8),
        .Depth    (120),
        .AW       (7),
        .BASE     (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_stall(core_stall),
        .core_flush(core_flush),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Log every memory write and every flush pulse seen at a clock edge.
    always @(posedge clk) begin
        if (mem_we) begin
            wrAddr.push_back(mem_addr);
            wrData.push_back(mem_wdata);
        end
        if (core_flush) flushCount++;
    end

    typedef struct {
        logic       st;
        logic       v;
        logic [7:0] d;
        logic       we;
        logic [6:0] a;
        logic [7:0] wd;
        logic       rdy;
        logic       fl;
        logic       stl;
        logic       bsy;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic v, logic [7:0] d, logic we, logic [6:0] a,
                                logic [7:0] wd, logic rdy, logic fl, logic stl, logic bsy,
                                logic dn, logic er);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.we = we; r.a = a; r.wd = wd;
        r.rdy = rdy; r.fl = fl; r.stl = stl; r.bsy = bsy; r.dn = dn; r.er = er;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic [7:0] d);
        @(negedge clk);
        start   = st;
        s_valid = v;
        s_data  = d;
    endtask

    task automatic chkOutputs(input string tag, input logic rdy, input logic fl,
                              input logic stl, input logic bsy, input logic dn, input logic er);
        chk({tag, " s_ready"},    s_ready,    rdy);
        chk({tag, " core_flush"}, core_flush, fl);
        chk({tag, " core_stall"}, core_stall, stl);
        chk({tag, " busy"},       busy,       bsy);
        chk({tag, " done"},       done,       dn);
        chk({tag, " err"},        err,        er);
    endtask

    task automatic chkWrites(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] expD[4];
        expD[0] = d0; expD[1] = d1; expD[2] = d2; expD[3] = d3;
        chk({tag, " write count"}, wrAddr.size(), 4);
        for (int k = 0; k < 4 && k < wrAddr.size(); k++) begin
            chk($sformatf("%s write%0d addr", tag, k), wrAddr[k], k);
            chk($sformatf("%s write%0d data", tag, k), wrData[k], expD[k]);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        #1;
        chk("reset mem_we",    mem_we,    0);
        chk("reset mem_addr",  mem_addr,  0);
        chk("reset mem_wdata", mem_wdata, 0);
        chkOutputs("reset", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // good frame, one start while busy ignored
        vecs.push_back(mk(1,0,8'h00, 0,0,8'h00, 0,0,1,0,0,0));
        vecs.push_back(mk(1,0,8'h00, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h04, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h13, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,0,8'h13, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,1,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,2,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h13, 1,3,8'h00, 1,1,1,1,0,0));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,0,0,1,0));
        // same frame, bad checksum
        vecs.push_back(mk(1,0,8'h00, 0,0,8'h00, 0,0,0,0,1,0));
        vecs.push_back(mk(0,1,8'h04, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h13, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,0,8'h13, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,1,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,2,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h14, 1,3,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,1,0,0,1));
        // length 121 exceeds depth
        vecs.push_back(mk(1,0,8'h00, 0,0,8'h00, 0,0,1,0,0,1));
        vecs.push_back(mk(0,1,8'h79, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,1,0,0,1));
        vecs.push_back(mk(0,1,8'h55, 0,0,8'h00, 0,0,1,0,0,1));
        // zero-length image
        vecs.push_back(mk(1,0,8'h00, 0,0,8'h00, 0,0,1,0,0,1));
        vecs.push_back(mk(0,1,8'h00, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 0,0,8'h00, 1,0,1,1,0,0));
        vecs.push_back(mk(0,1,8'h00, 0,0,8'h00, 1,1,1,1,0,0));
        vecs.push_back(mk(0,0,8'h00, 0,0,8'h00, 0,0,0,0,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].v, vecs[i].d);
            #1;
            chk($sformatf("vec%0d mem_we", i), mem_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d mem_addr", i),  mem_addr,  vecs[i].a);
                chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].wd);
            end
            chkOutputs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].fl, vecs[i].stl,
                       vecs[i].bsy, vecs[i].dn, vecs[i].er);
        end

        // stream stall of 5 cycles between payload bytes
        wrAddr.delete(); wrData.delete(); flushCount = 0;
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h04);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h13);
        repeat (5) begin
            drive(0, 0, 8'hAA);
            #1;
            chk("stall s_ready", s_ready, 1);
            chk("stall busy", busy, 1);
        end
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h13);
        #1;
        chk("stall csum flush", core_flush, 1);
        drive(0, 0, 8'h00);
        #1;
        chkOutputs("stall final", 0, 0, 0, 0, 1, 0);
        chk("stall flush pulses", flushCount, 1);
        chkWrites("stall", 8'h13, 8'h00, 8'h00, 8'h00);

        // reset while the payload byte at count 2 is presented
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h04);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h13);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst mem_we",    mem_we,    0);
        chk("midrst mem_addr",  mem_addr,  0);
        chk("midrst mem_wdata", mem_wdata, 0);
        chkOutputs("midrst", 0, 0, 1, 0, 0, 0);
        drive(0, 0, 8'h00);
        rst = 1'b0;
        wrAddr.delete(); wrData.delete(); flushCount = 0;
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h04);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h13);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h13);
        drive(0, 0, 8'h00);
        #1;
        chkOutputs("reload final", 0, 0, 0, 0, 1, 0);
        chk("reload flush pulses", flushCount, 1);
        chkWrites("reload", 8'h13, 8'h00, 8'h00, 8'h00);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that writes the byte-wide instruction memory read by the fetch stage.
- Receives a framed byte stream over a valid/ready interface and writes the payload bytes sequentially into the i-cache write port.
- Holds the pipeline in stall until the image is fully written and its checksum verified.
- On success, pulses a flush so fetch restarts cleanly from the loaded image.

Parameters:
ElemWidth, 8, memory element width in bits; the stream byte width is also ElemWidth.
Depth, 120, instruction memory depth in elements; the maximum payload length.
AW, 7, write-address width; must satisfy 2**AW >= Depth.
BASE, 0, first memory address written.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a load
s_valid  input  1  stream byte valid
s_data  input  ElemWidth  stream byte
s_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write enable
mem_addr  output  AW  instruction memory write address
mem_wdata  output  ElemWidth  instruction memory write data
core_stall  output  1  holds fetch/decode while not DONE
core_flush  output  1  one-cycle pulse when the load completes OK
busy  output  1  load in progress
done  output  1  image loaded and checksum matched (sticky)
err  output  1  length or checksum failure (sticky)

Behaviour:
- Reset (asynchronous): state IDLE, s_ready=0, mem_we=0, mem_addr=BASE, mem_wdata=0, core_stall=1, core_flush=0, busy=0, done=0, err=0, count=0, len=0, csum=0.
- Frame format: LEN_LO, LEN_HI (16-bit little-endian payload length N), N payload bytes, 1 checksum byte. The checksum byte equals the sum of the payload bytes mod 2**ElemWidth.
- Handshake: a byte transfers when s_valid && s_ready at the clk edge. s_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM. s_data is ignored when s_valid=0.
- IDLE: start moves to LEN_LO. busy=1 in every state except IDLE, DONE and ERR.
- LEN_LO: on a transfer, latch len[7:0] and go to LEN_HI.
- LEN_HI: on a transfer, latch len[15:8], then:
  - full len > Depth: go to ERR;
  - len == 0: go to CSUM;
  - otherwise go to DATA. count=0, csum=0.
- DATA: on each transfer, register the write. mem_we=1 in the next cycle with mem_addr=BASE+count and mem_wdata=byte (1-cycle write latency). csum += byte (wraps), count += 1. When count reaches len-1 on a transfer, go to CSUM.
- CSUM: on a transfer:
  - byte == csum: go to DONE. core_flush=1 for exactly that one transition cycle. core_stall=0 from the next cycle.
  - otherwise go to ERR.
- DONE: done=1, core_stall=0, s_ready=0. start re-enters LEN_LO, clears done and sets core_stall=1 in the next cycle.
- ERR: err=1, core_stall=1, s_ready=0. start clears err and re-enters LEN_LO.
- start while busy is ignored.
- Stream stalls (s_valid=0) in any state hold all state; no timeout.
- mem_we is never asserted outside the cycle that follows a DATA transfer. Back-to-back transfers produce back-to-back writes.
- Reset mid-load: immediately back to IDLE. Partially written memory is left as is; core_stall=1.
- The address never exceeds BASE+Depth-1, guaranteed by the length check.

Decomposition:
- Shared package rv32i_pkg:
  - loader_state_t enum {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR};
  - constant LEN_W=16.
- Single module; no sub-module needed. The FSM, address counter and checksum accumulator are small enough to be inlined.

Test Plan:
- Reset then start, stream 04 00 13 00 00 00 13 -> four writes addr 0..3, data 13,00,00,00; csum 13 matches; core_flush pulses once; done=1; core_stall=0.
- Same frame with checksum 14 -> no flush, err=1, core_stall=1, done=0.
- Length 79 00 (121 > Depth) -> ERR immediately after LEN_HI, no mem_we ever asserted.
- Length 00 00 followed by checksum 00 -> DONE with zero writes; flush pulse.
- Drop s_valid for 5 cycles between payload bytes -> no extra writes, addresses contiguous, same final memory content.
- Assert rst during the DATA byte at count 2 -> all outputs at reset values asynchronously. A subsequent start plus full frame loads correctly from BASE.
